udma_spim_reg_if_mch: RTL and testbench

//  Parametrised multi-channel register file for the uDMA SPI master.
//  - Holds startaddr/size/datasize/continuous for N_CH uDMA channels (ch0 = CMD, RX_CH, TX_CH).
//  - Decodes SETUP_UCA/UCS from the command stream.
//  - Buffers software writes that collide with command setups, so none are dropped.
//  - Counts end-of-transfer events per channel.

---
 rtl/udma_spim_reg_if_mch.sv | 234 +++++++++++++++++++++++
 tb/tb_udma_spim_reg_if_mch.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/udma_spim_reg_if_mch.sv
// Multi-channel uDMA SPI-master register file: per-channel config, command-stream setups,
// collision hold buffer. Optional per-channel EOT counters are built when SPIM_EOT_CNT_EN is defined.
module udma_spim_reg_if_mch #(
   parameter int L2_AWIDTH_NOAL = 12,
   parameter int TRANS_SIZE     = 16,
   parameter int N_CH           = 3,
   parameter int RX_CH          = 1,
   parameter int TX_CH          = 2
) (
   input  logic                           clk_i,
   input  logic                           rstn_i,
   input  logic [31:0]                    cfg_data_i,
   input  logic [4:0]                     cfg_addr_i,
   input  logic                           cfg_valid_i,
   input  logic                           cfg_rwn_i,
   output logic [31:0]                    cfg_data_o,
   output logic                           cfg_ready_o,
   output logic [N_CH*L2_AWIDTH_NOAL-1:0] cfg_startaddr_o,
   output logic [N_CH*TRANS_SIZE-1:0]     cfg_size_o,
   output logic [N_CH*2-1:0]              cfg_datasize_o,
   output logic [N_CH-1:0]                cfg_continuous_o,
   output logic [N_CH-1:0]                cfg_en_o,
   output logic [N_CH-1:0]                cfg_clr_o,
   input  logic [N_CH-1:0]                cfg_en_i,
   input  logic [N_CH-1:0]                cfg_pending_i,
   input  logic [N_CH*L2_AWIDTH_NOAL-1:0] cfg_curr_addr_i,
   input  logic [N_CH*TRANS_SIZE-1:0]     cfg_bytes_left_i,
   output logic                           cfg_avs_o,
   input  logic [1:0]                     status_i,
   input  logic [31:0]                    udma_cmd_i,
   input  logic                           udma_cmd_valid_i,
   input  logic                           udma_cmd_ready_i
);

   localparam int AW = L2_AWIDTH_NOAL;
   localparam int TS = TRANS_SIZE;
   localparam logic [3:0] SPI_CMD_SETUP_UCA = 4'hD;
   localparam logic [3:0] SPI_CMD_SETUP_UCS = 4'hE;
   localparam logic [4:0] ADDR_STATUS = 5'h18;
   localparam logic [4:0] ADDR_AVS    = 5'h19;

   typedef enum logic {IDLE, HOLD} state_t;
   state_t state_q, state_d;

   logic [AW-1:0] startaddr_q [N_CH];
   logic [AW-1:0] startaddr_d [N_CH];
   logic [TS-1:0] size_q      [N_CH];
   logic [TS-1:0] size_d      [N_CH];
   logic [1:0]    datasize_q  [N_CH];
   logic [1:0]    datasize_d  [N_CH];
   logic [N_CH-1:0] cont_q, cont_d, en_q, en_d, clr_q, clr_d;
   logic avs_q, avs_d;

   logic [4:0]  hold_addr_q;
   logic [31:0] hold_data_q;

   logic        is_uca, is_ucs, setup;
   logic [2:0]  cmd_ch;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;

   assign is_uca = udma_cmd_i[31:28] == SPI_CMD_SETUP_UCA;
   assign is_ucs = udma_cmd_i[31:28] == SPI_CMD_SETUP_UCS;
   assign setup  = udma_cmd_valid_i & udma_cmd_ready_i & (is_uca | is_ucs);
   assign cmd_ch = udma_cmd_i[27] ? 3'(TX_CH) : 3'(RX_CH);

   // FSM: state register
   always_ff @(posedge clk_i) begin
      if (!rstn_i) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (cfg_valid_i && !cfg_rwn_i && setup) state_d = HOLD;
         HOLD:    if (!setup) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cfg_ready_o = (state_q == IDLE);
   end

   // A write colliding with a setup is parked here; it is applied on the first setup-free cycle
   always_ff @(posedge clk_i) begin
      if (state_q == IDLE && state_d == HOLD) begin
         hold_addr_q <= cfg_addr_i;
         hold_data_q <= cfg_data_i;
      end
   end

   always_comb begin
      wr_en   = 1'b0;
      wr_addr = cfg_addr_i;
      wr_data = cfg_data_i;
      if (state_q == IDLE && cfg_valid_i && !cfg_rwn_i && !setup) begin
         wr_en = 1'b1;
      end else if (state_q == HOLD && !setup) begin
         wr_en   = 1'b1;
         wr_addr = hold_addr_q;
         wr_data = hold_data_q;
      end
   end

   always_comb begin
      cont_d = cont_q;
      en_d   = '0;
      clr_d  = '0;
      avs_d  = avs_q;
      for (int n = 0; n < N_CH; n++) begin
         startaddr_d[n] = startaddr_q[n];
         size_d[n]      = size_q[n];
         datasize_d[n]  = datasize_q[n];
         if (setup && cmd_ch == 3'(n)) begin
            if (is_uca) begin
               startaddr_d[n] = udma_cmd_i[AW-1:0];
            end else begin
               size_d[n] = udma_cmd_i[TS-1:0];
               if (n != 0) datasize_d[n] = udma_cmd_i[26:25];
               en_d[n] = 1'b1;
            end
         end
         if (wr_en && wr_addr[4:2] == 3'(n)) begin
            case (wr_addr[1:0])
               2'd0: startaddr_d[n] = wr_data[AW-1:0];
               2'd1: size_d[n]      = wr_data[TS-1:0];
               2'd2: begin
                  clr_d[n]  = wr_data[6];
                  en_d[n]   = wr_data[4];
                  cont_d[n] = wr_data[0];
                  if (n != 0) datasize_d[n] = wr_data[2:1];
               end
               default: ;
            endcase
         end
      end
      if (wr_en && wr_addr == ADDR_AVS) avs_d = wr_data[0];
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         for (int n = 0; n < N_CH; n++) begin
            startaddr_q[n] <= '0;
            size_q[n]      <= '0;
            datasize_q[n]  <= 2'b10;
         end
         cont_q <= '0;
         en_q   <= '0;
         clr_q  <= '0;
         avs_q  <= 1'b0;
      end else begin
         for (int n = 0; n < N_CH; n++) begin
            startaddr_q[n] <= startaddr_d[n];
            size_q[n]      <= size_d[n];
            datasize_q[n]  <= datasize_d[n];
         end
         cont_q <= cont_d;
         en_q   <= en_d;
         clr_q  <= clr_d;
         avs_q  <= avs_d;
      end
   end

   for (genvar g = 0; g < N_CH; g++) begin : g_out
      assign cfg_startaddr_o[g*AW +: AW] = startaddr_q[g];
      assign cfg_size_o[g*TS +: TS]      = size_q[g];
      assign cfg_datasize_o[g*2 +: 2]    = datasize_q[g];
   end
   assign cfg_continuous_o = cont_q;
   assign cfg_en_o         = en_q;
   assign cfg_clr_o        = clr_q;
   assign cfg_avs_o        = avs_q;

`ifdef SPIM_EOT_CNT_EN
   logic [N_CH-1:0] en_prev_q;
   logic [N_CH-1:0] eot_fall;
   logic [N_CH-1:0] eot_rd_clr;
   logic [7:0]      eot_cnt_q [N_CH];

   always_comb begin
      for (int n = 0; n < N_CH; n++) begin
         eot_fall[n]   = en_prev_q[n] & ~cfg_en_i[n];
         eot_rd_clr[n] = cfg_valid_i & cfg_ready_o & cfg_rwn_i & (cfg_addr_i == 5'(4*n+3));
      end
   end

   // A clearing read that coincides with an EOT leaves the counter at 1 so the event is not lost
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         en_prev_q <= '0;
         for (int n = 0; n < N_CH; n++) eot_cnt_q[n] <= '0;
      end else begin
         en_prev_q <= cfg_en_i;
         for (int n = 0; n < N_CH; n++) begin
            if (eot_rd_clr[n])
               eot_cnt_q[n] <= {7'd0, eot_fall[n]};
            else if (eot_fall[n] && eot_cnt_q[n] != 8'hFF)
               eot_cnt_q[n] <= eot_cnt_q[n] + 8'd1;
         end
      end
   end
`endif

   always_comb begin
      cfg_data_o = '0;
      if (cfg_addr_i == ADDR_STATUS) begin
         cfg_data_o = {30'd0, status_i};
      end else if (cfg_addr_i == ADDR_AVS) begin
         cfg_data_o = {31'd0, avs_q};
      end else begin
         for (int n = 0; n < N_CH; n++) begin
            if (cfg_addr_i[4:2] == 3'(n)) begin
               case (cfg_addr_i[1:0])
                  2'd0: cfg_data_o[AW-1:0] = cfg_curr_addr_i[n*AW +: AW];
                  2'd1: cfg_data_o[TS-1:0] = cfg_bytes_left_i[n*TS +: TS];
                  2'd2: cfg_data_o = {26'd0, cfg_pending_i[n], cfg_en_i[n], 1'b0,
                                      datasize_q[n], cont_q[n]};
`ifdef SPIM_EOT_CNT_EN
                  2'd3: cfg_data_o[7:0] = eot_cnt_q[n];
`endif
                  default: ;
               endcase
            end
         end
      end
   end

   logic unused_inputs;
   assign unused_inputs = ^{cfg_data_i, udma_cmd_i, cfg_en_i};

endmodule

// File: tb/tb_udma_spim_reg_if_mch.sv
// Directed bench for udma_spim_reg_if_mch (default parameters); EOTCNT expectations follow SPIM_EOT_CNT_EN.
module tb_udma_spim_reg_if_mch;

   localparam int N_CH = 3;
`ifdef SPIM_EOT_CNT_EN
   localparam bit EOT_ON = 1'b1;
`else
   localparam bit EOT_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rstn;
   logic [31:0] cfg_data_i;
   logic [4:0]  cfg_addr_i;
   logic        cfg_valid_i, cfg_rwn_i;
   logic [31:0] cfg_data_o;
   logic        cfg_ready_o;
   logic [35:0] cfg_startaddr_o;
   logic [47:0] cfg_size_o;
   logic [5:0]  cfg_datasize_o;
   logic [2:0]  cfg_continuous_o, cfg_en_o, cfg_clr_o;
   logic [2:0]  cfg_en_i, cfg_pending_i;
   logic [35:0] cfg_curr_addr_i;
   logic [47:0] cfg_bytes_left_i;
   logic        cfg_avs_o;
   logic [1:0]  status_i;
   logic [31:0] udma_cmd_i;
   logic        udma_cmd_valid_i, udma_cmd_ready_i;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] rdata;

   always #5 clk = ~clk;

   udma_spim_reg_if_mch dut (
      .clk_i(clk), .rstn_i(rstn),
      .cfg_data_i(cfg_data_i), .cfg_addr_i(cfg_addr_i), .cfg_valid_i(cfg_valid_i),
      .cfg_rwn_i(cfg_rwn_i), .cfg_data_o(cfg_data_o), .cfg_ready_o(cfg_ready_o),
      .cfg_startaddr_o(cfg_startaddr_o), .cfg_size_o(cfg_size_o),
      .cfg_datasize_o(cfg_datasize_o), .cfg_continuous_o(cfg_continuous_o),
      .cfg_en_o(cfg_en_o), .cfg_clr_o(cfg_clr_o), .cfg_en_i(cfg_en_i),
      .cfg_pending_i(cfg_pending_i), .cfg_curr_addr_i(cfg_curr_addr_i),
      .cfg_bytes_left_i(cfg_bytes_left_i), .cfg_avs_o(cfg_avs_o), .status_i(status_i),
      .udma_cmd_i(udma_cmd_i), .udma_cmd_valid_i(udma_cmd_valid_i),
      .udma_cmd_ready_i(udma_cmd_ready_i)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      cfg_addr_i = a; cfg_data_i = d; cfg_rwn_i = 1'b0; cfg_valid_i = 1'b1;
      tick();
      cfg_valid_i = 1'b0;
   endtask

   task automatic rd(input logic [4:0] a, output logic [31:0] d);
      cfg_addr_i = a; cfg_rwn_i = 1'b1; cfg_valid_i = 1'b1;
      #1;
      d = cfg_data_o;
      tick();
      cfg_valid_i = 1'b0;
   endtask

   task automatic cmd(input logic [31:0] c);
      udma_cmd_i = c; udma_cmd_valid_i = 1'b1; udma_cmd_ready_i = 1'b1;
   endtask

   task automatic cmd_off();
      udma_cmd_valid_i = 1'b0; udma_cmd_i = '0;
   endtask

   initial begin
      rstn = 1'b0; cfg_data_i = '0; cfg_addr_i = '0; cfg_valid_i = 1'b0; cfg_rwn_i = 1'b1;
      cfg_en_i = '0; cfg_pending_i = '0; cfg_curr_addr_i = '0; cfg_bytes_left_i = '0;
      status_i = '0; udma_cmd_i = '0; udma_cmd_valid_i = 1'b0; udma_cmd_ready_i = 1'b1;
      tick(); tick();
      check("rst_size", cfg_size_o, 48'h0);
      check("rst_datasize", cfg_datasize_o, 6'b101010);
      check("rst_ready", cfg_ready_o, 1'b1);
      check("rst_en_clr", {cfg_en_o, cfg_clr_o}, 6'b0);
      check("rst_saddr_avs", {cfg_startaddr_o, cfg_avs_o}, 37'h0);
      rstn = 1'b1;

      // CFG ch2 = 0x15: enable pulse, datasize 10, continuous
      wr(5'h0A, 32'h15);
      check("cfg_en_pulse", cfg_en_o, 3'b100);
      check("cfg_ds2", cfg_datasize_o[5:4], 2'b10);
      check("cfg_cont", cfg_continuous_o, 3'b100);
      tick();
      check("cfg_en_drop", cfg_en_o, 3'b000);

      // UCS to TX channel colliding with SIZE ch2 write
      cmd(32'hEA00_0040);
      wr(5'h09, 32'h80);
      cmd_off();
      check("ucs_size", cfg_size_o[47:32], 16'h40);
      check("ucs_en", cfg_en_o, 3'b100);
      check("ucs_ds", cfg_datasize_o[5:4], 2'b01);
      check("ucs_ready0", cfg_ready_o, 1'b0);
      tick();
      check("held_size", cfg_size_o[47:32], 16'h80);
      check("held_ready1", cfg_ready_o, 1'b1);
      check("held_en0", cfg_en_o, 3'b000);

      // back-to-back UCA setups to RX channel while a SADDR write is held
      cmd(32'hD000_0123);
      wr(5'h04, 32'h555);
      check("uca1", cfg_startaddr_o[23:12], 12'h123);
      check("uca1_ready", cfg_ready_o, 1'b0);
      cmd(32'hD000_0234);
      tick();
      check("uca2", cfg_startaddr_o[23:12], 12'h234);
      check("uca2_ready", cfg_ready_o, 1'b0);
      cmd(32'hD000_0345);
      tick();
      check("uca3", cfg_startaddr_o[23:12], 12'h345);
      check("uca3_ready", cfg_ready_o, 1'b0);
      cmd_off();
      tick();
      check("uca_held", cfg_startaddr_o[23:12], 12'h555);
      check("uca_ready", cfg_ready_o, 1'b1);

      // ch0 datasize is fixed; clr pulse; AVS
      wr(5'h02, 32'h0);
      check("ch0_ds", cfg_datasize_o[1:0], 2'b10);
      wr(5'h06, 32'h44);
      check("clr_pulse", {cfg_clr_o, cfg_en_o}, 6'b010_000);
      wr(5'h19, 32'h1);
      check("avs", cfg_avs_o, 1'b1);

      // reads
      rd(5'h19, rdata);  check("rd_avs", rdata, 32'h1);
      rd(5'h02, rdata);  check("rd_cfg0", rdata, 32'h4);
      status_i = 2'b11;
      rd(5'h18, rdata);  check("rd_status", rdata, 32'h3);
      cfg_curr_addr_i = 36'h000_ABC_000;
      rd(5'h04, rdata);  check("rd_saddr1", rdata, 32'hABC);
      cfg_bytes_left_i = 48'h1234_0000_0000;
      rd(5'h09, rdata);  check("rd_size2", rdata, 32'h1234);
      cfg_pending_i = 3'b100;
      rd(5'h0A, rdata);  check("rd_cfg2", rdata, 32'h23);
      cfg_pending_i = '0;

      // three EOTs on ch1
      for (int i = 0; i < 3; i++) begin
         cfg_en_i = 3'b010; tick();
         cfg_en_i = 3'b000; tick();
      end
      rd(5'h07, rdata);  check("eot1_first", rdata, EOT_ON ? 32'd3 : 32'd0);
      rd(5'h07, rdata);  check("eot1_second", rdata, 32'd0);

      // saturation on ch0, then read coinciding with an EOT
      for (int i = 0; i < 300; i++) begin
         cfg_en_i = 3'b001; tick();
         cfg_en_i = 3'b000; tick();
      end
      cfg_en_i = 3'b001; tick();
      cfg_en_i = 3'b000;
      rd(5'h03, rdata);  check("eot0_sat", rdata, EOT_ON ? 32'd255 : 32'd0);
      rd(5'h03, rdata);  check("eot0_rdinc", rdata, EOT_ON ? 32'd1 : 32'd0);
      rd(5'h03, rdata);  check("eot0_clear", rdata, 32'd0);

      // unmapped address
      wr(5'h1F, 32'hFFFF_FFFF);
      check("unmap_saddr", cfg_startaddr_o, 36'h000_555_000);
      check("unmap_size", cfg_size_o, 48'h0080_0000_0000);
      check("unmap_ds_cont", {cfg_datasize_o, cfg_continuous_o, cfg_avs_o}, {6'b011010, 3'b100, 1'b1});
      check("unmap_pulses", {cfg_en_o, cfg_clr_o}, 6'b0);
      rd(5'h1F, rdata);  check("rd_unmap", rdata, 32'h0);

      // reset during HOLD drops the held write
      cmd(32'hD000_0111);
      wr(5'h04, 32'h777);
      cmd_off();
      check("pre_rst_hold", cfg_ready_o, 1'b0);
      rstn = 1'b0;
      tick();
      rstn = 1'b1;
      tick();
      check("rst_hold_saddr", cfg_startaddr_o, 36'h0);
      check("rst_hold_ready", cfg_ready_o, 1'b1);
      check("rst_hold_ds", cfg_datasize_o, 6'b101010);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
